seq_alu_calc: RTL and testbench
===============================

# seq_alu_calc

Parametrised multi-cycle calculator for the FPGA datapath. Operand width is configurable. Multiply and divide are iterative (shift-add and restoring) instead of combinational. Status flags are produced with the result, and an accumulate mode chains results across operations. It keeps the existing button-level handshake: one operation per start assertion, and the result is held until the next operation completes.

## Interface
- W, 8: operand width in bits, W ≥ 2; result is 2W bits
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  level request (button); one launch per assertion
- op  in  3  000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 XOR, 111 NOT
- acc_en  in  1  1: operand A = result[W-1:0] of previous op instead of a
- a  in  W  operand A
- b  in  W  operand B
- result  out  2W  operation result, held between operations
- busy  out  1  operation in progress
- done  out  1  result valid; held until start drops
- carry  out  1  ADD carry-out / SUB borrow
- dbz  out  1  divide by zero
- zero  out  1  result == 0

## Operation
- States: IDLE, CALC (single-cycle ops, DIV by zero), ITER (MUL/DIV with b≠0), DONE.
- IDLE with start=1: latch op, A (a or result[W-1:0] per acc_en) and b; go to CALC or ITER; busy←1.
- CALC: write result and flags, done←1, busy←0, go to DONE.
- ITER: W iteration cycles driven by a counter 0..W-1. The last iteration writes result and flags, done←1, busy←0, go to DONE.
- DONE with start=0: done←0, go to IDLE. While start stays 1 there is no relaunch.
- Arithmetic, unsigned:
  - ADD: result = {0, A+b} (W+1 bits); carry = bit W.
  - SUB: result[W-1:0] = (A−b) mod 2^W, upper bits 0; carry = (A<b).
  - MUL: result = full 2W-bit product via shift-add, one partial product per iteration.
  - DIV, b≠0: restoring division, one quotient bit per iteration; result = {remainder, quotient}.
  - DIV, b=0: handled in CALC; dbz=1, quotient = all ones, remainder = A.
  - AND/OR/XOR/NOT: bitwise on low W bits (NOT uses A only), upper W bits 0.
- Flags:
  - carry = 0 for ops other than ADD/SUB.
  - dbz = 0 except DIV by zero.
  - zero computed on the full 2W-bit result written.
  - All flags update only when result updates.
- result and flags persist through IDLE, a new launch, and busy; they change only at completion.
- During CALC/ITER/DONE, changes on a, b, op, acc_en and start are ignored, except start=0 in DONE.
- rst, including mid-ITER: state IDLE, counter 0, result/busy/done/carry/dbz/zero = 0; the partial operation is discarded. acc_en after reset uses A = 0.

## Timing
- Launch edge N = first rising edge with state IDLE and start=1.
- busy=1 after edge N.
- ADD/SUB/AND/OR/XOR/NOT, and DIV with b=0: result, flags and done valid after edge N+1; busy=0 after edge N+1.
- MUL, and DIV with b≠0: result, flags and done valid after edge N+W; busy=1 for exactly W cycles.
- done falls after the first edge in DONE that samples start=0.
- The earliest next launch is the following edge, if start=1 again.
- start high for a single cycle is sufficient to launch; done then clears one edge after done rises.
- Reset values of all outputs: 0.

## Test plan
All scenarios use W=8.
- ADD a=200, b=100, start pulse → after N+1: result=0x012C, carry=1, zero=0, done=1. done clears one edge after start low.
- MUL a=255, b=255 → busy=1 for 8 cycles; after N+8: result=0xFE01, done=1. a/b changed mid-op have no effect.
- DIV a=200, b=7 → after N+8: result=0x041C (rem 4, quo 28), dbz=0. DIV a=13, b=0 → after N+1: result=0x0DFF, dbz=1.
- SUB a=5, b=9 → result=0x00FC, carry=1. SUB a=9, b=9 → result=0x0000, zero=1, carry=0.
- Accumulate: ADD 3+4 → 0x0007; release start; then acc_en=1, MUL b=6, a=99 → 0x002A.
- rst at N+3 of a MUL → all outputs 0 next edge, state IDLE. start held high after done → exactly one launch, no repeat.

Source files
------------

// File: rtl/seq_alu_calc_if.sv
// Bus bundle for seq_alu_calc: request side (start/op/operands) and
// result side (result plus status flags and handshake).
interface seq_alu_calc_if #(
  parameter int W = 8
) ();
  logic           start;
  logic [2:0]     op;
  logic           acc_en;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] result;
  logic           busy;
  logic           done;
  logic           carry;
  logic           dbz;
  logic           zero;

  modport master (
    output start, op, acc_en, a, b,
    input  result, busy, done, carry, dbz, zero
  );

  modport slave (
    input  start, op, acc_en, a, b,
    output result, busy, done, carry, dbz, zero
  );
endinterface

// File: rtl/seq_alu_calc.sv
// Multi-cycle unsigned calculator. Single-cycle ops finish in one CALC
// cycle; MUL (shift-add) and DIV (restoring) take W ITER cycles. Result and
// flags are registered and only change when an operation completes.
module seq_alu_calc #(
  parameter int W = 8
) (
  input  logic               clk,
  input  logic               rst,
  seq_alu_calc_if.slave      bus
);
  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] result_q, result_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           carry_q, carry_d;
  logic           dbz_q, dbz_d;
  logic           zero_q, zero_d;

  // Launch-time operand selection and iterative-path decision
  logic [W-1:0]   a_sel_s;
  logic           launch_iter_s;

  // Single-cycle results
  logic [2*W-1:0] calc_res_s;
  logic           calc_carry_s;
  logic           calc_dbz_s;
  logic [W:0]     sum_s;

  // One iteration of shift-add / restoring division
  logic [2*W-1:0] iter_next_s;
  logic [W:0]     trial_s;
  logic [W-1:0]   rem_sub_s;

  assign bus.result = result_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.carry  = carry_q;
  assign bus.dbz    = dbz_q;
  assign bus.zero   = zero_q;

  // Pick operand A and decide whether the requested op needs the iterative path
  always_comb begin
    a_sel_s       = bus.acc_en ? result_q[W-1:0] : bus.a;
    launch_iter_s = (bus.op == OP_MUL) ||
                    ((bus.op == OP_DIV) && (bus.b != {W{1'b0}}));
  end

  // Single-cycle datapath: add/sub/logic ops and divide-by-zero
  always_comb begin
    sum_s        = {1'b0, a_q} + {1'b0, b_q};
    calc_res_s   = {(2*W){1'b0}};
    calc_carry_s = 1'b0;
    calc_dbz_s   = 1'b0;
    case (op_q)
      OP_ADD: begin
        calc_res_s   = {{(W-1){1'b0}}, sum_s};
        calc_carry_s = sum_s[W];
      end
      OP_SUB: begin
        calc_res_s   = {{W{1'b0}}, a_q - b_q};
        calc_carry_s = (a_q < b_q);
      end
      OP_DIV: begin
        // Only reaches CALC with b == 0: quotient saturates, remainder = A
        calc_res_s = {a_q, {W{1'b1}}};
        calc_dbz_s = 1'b1;
      end
      OP_AND:  calc_res_s = {{W{1'b0}}, a_q & b_q};
      OP_OR:   calc_res_s = {{W{1'b0}}, a_q | b_q};
      OP_XOR:  calc_res_s = {{W{1'b0}}, a_q ^ b_q};
      OP_NOT:  calc_res_s = {{W{1'b0}}, ~a_q};
      default: calc_res_s = {(2*W){1'b0}};
    endcase
  end

  // Iterative datapath: MUL adds A<<cnt when b[cnt] is set; DIV keeps
  // {remainder, dividend/quotient} in acc and shifts one quotient bit in
  always_comb begin
    trial_s     = {acc_q[2*W-1:W], acc_q[W-1]};
    rem_sub_s   = trial_s[W-1:0] - b_q;
    iter_next_s = acc_q;
    if (op_q == OP_MUL) begin
      if (b_q[cnt_q]) begin
        iter_next_s = acc_q + ({{W{1'b0}}, a_q} << cnt_q);
      end else begin
        iter_next_s = acc_q;
      end
    end else begin
      if (trial_s >= {1'b0, b_q}) begin
        iter_next_s = {rem_sub_s, acc_q[W-2:0], 1'b1};
      end else begin
        iter_next_s = {trial_s[W-1:0], acc_q[W-2:0], 1'b0};
      end
    end
  end

  // Control FSM next-state and registered-output next values
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = done_q;
    carry_d  = carry_q;
    dbz_d    = dbz_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d   = bus.op;
          a_d    = a_sel_s;
          b_d    = bus.b;
          cnt_d  = {CW{1'b0}};
          busy_d = 1'b1;
          if (launch_iter_s) begin
            state_d = S_ITER;
            if (bus.op == OP_DIV) begin
              acc_d = {{W{1'b0}}, a_sel_s};
            end else begin
              acc_d = {(2*W){1'b0}};
            end
          end else begin
            state_d = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        result_d = calc_res_s;
        carry_d  = calc_carry_s;
        dbz_d    = calc_dbz_s;
        zero_d   = (calc_res_s == {(2*W){1'b0}});
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_DONE;
      end
      S_ITER: begin
        acc_d = iter_next_s;
        if (cnt_q == CNT_LAST) begin
          result_d = iter_next_s;
          carry_d  = 1'b0;
          dbz_d    = 1'b0;
          zero_d   = (iter_next_s == {(2*W){1'b0}});
          done_d   = 1'b1;
          busy_d   = 1'b0;
          cnt_d    = {CW{1'b0}};
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      S_DONE: begin
        if (!bus.start) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CW{1'b0}};
      op_q     <= 3'b000;
      a_q      <= {W{1'b0}};
      b_q      <= {W{1'b0}};
      acc_q    <= {(2*W){1'b0}};
      result_q <= {(2*W){1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      carry_q  <= 1'b0;
      dbz_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      carry_q  <= carry_d;
      dbz_q    <= dbz_d;
      zero_q   <= zero_d;
    end
  end
endmodule

// File: tb/tb_seq_alu_calc.sv
// Directed testbench for seq_alu_calc (W=8) with hand-computed expectations.
module tb_seq_alu_calc;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  seq_alu_calc_if #(.W(8)) bus_if ();

  seq_alu_calc #(.W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  // Free-running clock, 10 time-unit period
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch with a one-cycle start pulse, scramble inputs mid-op, and check
  // busy/done timing up to the completion edge (lat edges after launch).
  task automatic run_op(input string tag, input logic [2:0] o, input logic [7:0] av,
                        input logic [7:0] bv, input logic acc, input int lat);
    bus_if.op     = o;
    bus_if.a      = av;
    bus_if.b      = bv;
    bus_if.acc_en = acc;
    bus_if.start  = 1'b1;
    step();
    chk_eq({tag, " busy@launch"}, 32'(bus_if.busy), 32'd1);
    bus_if.start  = 1'b0;
    bus_if.acc_en = ~acc;
    bus_if.a      = ~av;
    bus_if.b      = av ^ bv ^ 8'h5A;
    bus_if.op     = ~o;
    for (int i = 1; i < lat; i++) begin
      step();
      chk_eq({tag, " busy mid"}, 32'(bus_if.busy), 32'd1);
      chk_eq({tag, " done mid"}, 32'(bus_if.done), 32'd0);
    end
    step();
    chk_eq({tag, " done"}, 32'(bus_if.done), 32'd1);
    chk_eq({tag, " busy end"}, 32'(bus_if.busy), 32'd0);
    bus_if.acc_en = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic [15:0] r, input logic cy,
                         input logic dz, input logic zr);
    chk_eq({tag, " result"}, 32'(bus_if.result), 32'(r));
    chk_eq({tag, " carry"}, 32'(bus_if.carry), 32'(cy));
    chk_eq({tag, " dbz"}, 32'(bus_if.dbz), 32'(dz));
    chk_eq({tag, " zero"}, 32'(bus_if.zero), 32'(zr));
    step();
    chk_eq({tag, " done clr"}, 32'(bus_if.done), 32'd0);
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    clk           = 1'b0;
    rst           = 1'b1;
    bus_if.start  = 1'b0;
    bus_if.op     = 3'b000;
    bus_if.acc_en = 1'b0;
    bus_if.a      = 8'h00;
    bus_if.b      = 8'h00;
    step();
    step();
    rst = 1'b0;
    chk_eq("rst result", 32'(bus_if.result), 32'd0);
    chk_eq("rst busy", 32'(bus_if.busy), 32'd0);
    chk_eq("rst done", 32'(bus_if.done), 32'd0);
    chk_eq("rst flags", {29'd0, bus_if.carry, bus_if.dbz, bus_if.zero}, 32'd0);

    run_op("add", 3'b000, 8'd200, 8'd100, 1'b0, 1);
    chk_res("add", 16'h012C, 1'b1, 1'b0, 1'b0);

    // MUL: result must hold the previous value while busy
    bus_if.op = 3'b010; bus_if.a = 8'd255; bus_if.b = 8'd255; bus_if.start = 1'b1;
    step();
    bus_if.start = 1'b0; bus_if.a = 8'd1; bus_if.b = 8'd2;
    step();
    chk_eq("mul hold result", 32'(bus_if.result), 32'h012C);
    chk_eq("mul hold carry", 32'(bus_if.carry), 32'd1);
    for (int i = 2; i < 8; i++) begin
      step();
      chk_eq("mul busy mid", 32'(bus_if.busy), 32'd1);
    end
    step();
    chk_eq("mul done", 32'(bus_if.done), 32'd1);
    chk_res("mul", 16'hFE01, 1'b0, 1'b0, 1'b0);

    run_op("div", 3'b011, 8'd200, 8'd7, 1'b0, 8);
    chk_res("div", 16'h041C, 1'b0, 1'b0, 1'b0);
    run_op("div0", 3'b011, 8'd13, 8'd0, 1'b0, 1);
    chk_res("div0", 16'h0DFF, 1'b0, 1'b1, 1'b0);
    run_op("sub", 3'b001, 8'd5, 8'd9, 1'b0, 1);
    chk_res("sub", 16'h00FC, 1'b1, 1'b0, 1'b0);
    run_op("sub eq", 3'b001, 8'd9, 8'd9, 1'b0, 1);
    chk_res("sub eq", 16'h0000, 1'b0, 1'b0, 1'b1);
    run_op("and", 3'b100, 8'hF0, 8'h3C, 1'b0, 1);
    chk_res("and", 16'h0030, 1'b0, 1'b0, 1'b0);
    run_op("or", 3'b101, 8'hF0, 8'h3C, 1'b0, 1);
    chk_res("or", 16'h00FC, 1'b0, 1'b0, 1'b0);
    run_op("xor", 3'b110, 8'hF0, 8'h3C, 1'b0, 1);
    chk_res("xor", 16'h00CC, 1'b0, 1'b0, 1'b0);
    run_op("not", 3'b111, 8'hF0, 8'h3C, 1'b0, 1);
    chk_res("not", 16'h000F, 1'b0, 1'b0, 1'b0);

    run_op("acc add", 3'b000, 8'd3, 8'd4, 1'b0, 1);
    chk_res("acc add", 16'h0007, 1'b0, 1'b0, 1'b0);
    run_op("acc mul", 3'b010, 8'd99, 8'd6, 1'b1, 8);
    chk_res("acc mul", 16'h002A, 1'b0, 1'b0, 1'b0);

    // Reset lands on edge N+3 of a MUL
    bus_if.op = 3'b010; bus_if.a = 8'd255; bus_if.b = 8'd255; bus_if.start = 1'b1;
    step();
    bus_if.start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_eq("midrst result", 32'(bus_if.result), 32'd0);
    chk_eq("midrst busy", 32'(bus_if.busy), 32'd0);
    chk_eq("midrst done", 32'(bus_if.done), 32'd0);
    chk_eq("midrst flags", {29'd0, bus_if.carry, bus_if.dbz, bus_if.zero}, 32'd0);
    step();
    chk_eq("midrst idle busy", 32'(bus_if.busy), 32'd0);
    run_op("rst acc", 3'b000, 8'd77, 8'd5, 1'b1, 1);
    chk_res("rst acc", 16'h0005, 1'b0, 1'b0, 1'b0);

    // start held high after done: exactly one launch
    bus_if.op = 3'b000; bus_if.a = 8'd1; bus_if.b = 8'd1; bus_if.start = 1'b1;
    step();
    step();
    chk_eq("hold done", 32'(bus_if.done), 32'd1);
    chk_eq("hold result", 32'(bus_if.result), 32'h0002);
    bus_if.a = 8'd10;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_eq("hold done stays", 32'(bus_if.done), 32'd1);
      chk_eq("hold no relaunch", 32'(bus_if.busy), 32'd0);
    end
    bus_if.start = 1'b0;
    step();
    chk_eq("hold done clr", 32'(bus_if.done), 32'd0);
    step();
    chk_eq("hold idle busy", 32'(bus_if.busy), 32'd0);
    chk_eq("hold result kept", 32'(bus_if.result), 32'h0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
